// File: rtl/scroll_line_prefetch.sv
// scroll_line_prefetch: prefetches one scrolled background scanline from SRAM into a
// ping-pong line buffer while the other half is read out for display.
module scroll_line_prefetch #(
  parameter int PIX_W   = 5,
  parameter int H_RES   = 640,
  parameter int LEVEL_W = 8192,
  parameter int ADDR_W  = 20,
  parameter int STEP_W  = 3
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       line_start_i,
  input  logic [9:0]                 line_y_i,
  input  logic                       frame_tick_i,
  input  logic                       scroll_en_i,
  input  logic                       scroll_dir_i,
  input  logic [STEP_W-1:0]          scroll_step_i,
  input  logic [15:0]                sram_data_i,
  output logic [ADDR_W-1:0]          sram_addr_o,
  output logic                       sram_oe_n_o,
  input  logic [9:0]                 rd_x_i,
  output logic [PIX_W-1:0]           rd_pixel_o,
  output logic [$clog2(LEVEL_W)-1:0] frame_ptr_o,
  output logic                       fetch_busy_o,
  output logic                       fetch_overrun_o
);
  localparam int LW = $clog2(LEVEL_W);
  localparam int XW = $clog2(H_RES + 1);
  localparam int IW = $clog2(H_RES);
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t            state_q;
  logic [XW-1:0]     x_q, x_d;
  logic [9:0]        y_s_q, y_d;
  logic [LW-1:0]     ptr_s_q, ptr_d, col, frame_ptr_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              disp_q, overrun_q, oe_n_q, wr_en;
  logic [1:0]        valid_q;
  logic [PIX_W-1:0]  pix_q;
  logic [PIX_W-1:0]  buf_q [2][H_RES];
  logic [IW-1:0]     wr_idx;
  logic              unused_bits;
  assign unused_bits = ^sram_data_i[15:PIX_W];
  // Address generation looks one column ahead so sram_addr_o is a clean register.
  always_comb begin
    y_d    = line_start_i ? line_y_i : y_s_q;
    ptr_d  = line_start_i ? frame_ptr_q : ptr_s_q;
    x_d    = line_start_i ? '0 : x_q + 1'b1;
    col    = ptr_d + LW'(x_d);
    addr_d = ADDR_W'({y_d, col});
    wr_en  = !reset_i && ((state_q == FETCH && x_q != '0) || state_q == DRAIN);
    wr_idx = IW'(x_q - 1'b1);
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_s_q       <= '0;
      ptr_s_q     <= '0;
      frame_ptr_q <= '0;
      addr_q      <= '0;
      oe_n_q      <= 1'b1;
      disp_q      <= 1'b0;
      valid_q     <= '0;
      overrun_q   <= 1'b0;
      pix_q       <= '0;
    end else begin
      pix_q <= (32'(rd_x_i) < H_RES && valid_q[disp_q]) ? buf_q[disp_q][IW'(rd_x_i)] : '0;
      if (frame_tick_i && scroll_en_i)
        frame_ptr_q <= scroll_dir_i ? frame_ptr_q - LW'(scroll_step_i) : frame_ptr_q + LW'(scroll_step_i);
      if (line_start_i) begin
        state_q         <= FETCH;
        x_q             <= '0;
        y_s_q           <= line_y_i;
        ptr_s_q         <= frame_ptr_q;
        addr_q          <= addr_d;
        oe_n_q          <= 1'b0;
        disp_q          <= ~disp_q;
        valid_q[disp_q] <= 1'b0;
        // An interrupted fill becomes the display half, so it must read as blank.
        if (state_q != IDLE) valid_q[~disp_q] <= 1'b0;
        overrun_q       <= overrun_q | (state_q != IDLE);
      end else if (state_q == FETCH) begin
        x_q     <= x_d;
        state_q <= (x_q == X_LAST) ? DRAIN : FETCH;
        addr_q  <= (x_q == X_LAST) ? '0 : addr_d;
        oe_n_q  <= x_q == X_LAST;
      end else if (state_q == DRAIN) begin
        state_q          <= IDLE;
        valid_q[~disp_q] <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i)
    if (wr_en) buf_q[~disp_q][wr_idx] <= sram_data_i[PIX_W-1:0];
  assign sram_addr_o     = addr_q;
  assign sram_oe_n_o     = oe_n_q;
  assign rd_pixel_o      = pix_q;
  assign frame_ptr_o     = frame_ptr_q;
  assign fetch_busy_o    = state_q != IDLE;
  assign fetch_overrun_o = overrun_q;
endmodule

// File: tb/tb_scroll_line_prefetch.sv
// tb_scroll_line_prefetch: directed bench; expected SRAM addresses are queued per fetch
// and popped by a monitor whenever the DUT drives the SRAM.
module tb_scroll_line_prefetch;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        line_start = 1'b0;
  logic [9:0]  line_y = '0;
  logic        frame_tick = 1'b0;
  logic        scroll_en = 1'b0;
  logic        scroll_dir = 1'b0;
  logic [2:0]  scroll_step = '0;
  logic [15:0] sram_data = '0;
  logic [19:0] sram_addr;
  logic        sram_oe_n;
  logic [9:0]  rd_x = '0;
  logic [4:0]  rd_pixel;
  logic [12:0] frame_ptr;
  logic        fetch_busy;
  logic        fetch_overrun;
  int          total = 0;
  int          bad = 0;
  logic [19:0] exp_q [$];
  logic [12:0] fp = '0;
  scroll_line_prefetch dut (
    .clk_i(clk), .reset_i(reset), .line_start_i(line_start), .line_y_i(line_y),
    .frame_tick_i(frame_tick), .scroll_en_i(scroll_en), .scroll_dir_i(scroll_dir),
    .scroll_step_i(scroll_step), .sram_data_i(sram_data), .sram_addr_o(sram_addr),
    .sram_oe_n_o(sram_oe_n), .rd_x_i(rd_x), .rd_pixel_o(rd_pixel), .frame_ptr_o(frame_ptr),
    .fetch_busy_o(fetch_busy), .fetch_overrun_o(fetch_overrun)
  );
  always #5 clk = ~clk;
  // Synchronous SRAM model: data for an address appears the cycle after it is issued.
  always @(posedge clk) sram_data <= {11'd0, sram_addr[4:0]};
  always @(negedge clk) begin
    if (!sram_oe_n) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sram_addr unexpected: got %0d, none queued", sram_addr);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if (sram_addr !== e) begin
          bad++;
          $display("FAIL sram_addr: got %0d expected %0d", sram_addr, e);
        end
      end
    end
  end
  function automatic logic [19:0] exp_addr(input int y, input int p, input int x);
    return 20'((y * 8192) + ((p + x) % 8192));
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] e);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, e);
    end
  endtask
  task automatic pulse(input int y, input bit tick, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_addr(y, int'(fp), i));
    line_y = 10'(y);
    line_start = 1'b1;
    frame_tick = tick;
    @(negedge clk);
    line_start = 1'b0;
    frame_tick = 1'b0;
    if (tick && scroll_en) fp = scroll_dir ? fp - 13'(scroll_step) : fp + 13'(scroll_step);
  endtask
  task automatic tick(input bit en, input bit dir, input int step);
    scroll_en = en;
    scroll_dir = dir;
    scroll_step = 3'(step);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    if (en) fp = dir ? fp - 13'(step) : fp + 13'(step);
  endtask
  task automatic rd(input string nm, input int x, input int e);
    rd_x = 10'(x);
    @(negedge clk);
    chk(nm, 32'(rd_pixel), 32'(e));
  endtask
  task automatic wait_idle();
    int c = 0;
    while (fetch_busy && c < 2000) begin
      c++;
      @(negedge clk);
    end
    chk("fetch_done", 32'(fetch_busy), 0);
  endtask
  initial begin
    int c;
    @(negedge clk);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_frame_ptr", 32'(frame_ptr), 0);
    chk("rst_busy", 32'(fetch_busy), 0);
    chk("rst_overrun", 32'(fetch_overrun), 0);
    chk("rst_oe_n", 32'(sram_oe_n), 1);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_pixel", 32'(rd_pixel), 0);
    // First fetch: line 0, no scroll; busy window length
    pulse(0, 1'b0, 640);
    c = 0;
    while (fetch_busy && c < 2000) begin
      c++;
      @(negedge clk);
    end
    chk("busy_len", 32'(c), 641);
    rd("rd_first_invalid", 37, 0);
    pulse(1, 1'b0, 640);
    rd("rd_x37", 37, 5);
    rd("rd_x639", 639, 31);
    rd("rd_x640_oob", 640, 0);
    wait_idle();
    // Forward scroll, disabled tick, zero step
    repeat (4) tick(1'b1, 1'b0, 3);
    chk("fp_12", 32'(frame_ptr), 12);
    tick(1'b0, 1'b0, 3);
    chk("fp_en0", 32'(frame_ptr), 12);
    tick(1'b1, 1'b0, 0);
    chk("fp_step0", 32'(frame_ptr), 12);
    pulse(2, 1'b0, 640);
    chk("addr_y2_start", 32'(sram_addr), 16396);
    wait_idle();
    // Backward scroll with wrap, then fetch across the level seam
    repeat (2) tick(1'b1, 1'b1, 4);
    chk("fp_4", 32'(frame_ptr), 4);
    tick(1'b1, 1'b1, 2);
    chk("fp_2", 32'(frame_ptr), 2);
    tick(1'b1, 1'b1, 4);
    chk("fp_wrap_8190", 32'(frame_ptr), 8190);
    pulse(0, 1'b0, 640);
    chk("addr_wrap_start", 32'(sram_addr), 8190);
    wait_idle();
    // frame_tick coincident with line_start
    tick(1'b1, 1'b0, 2);
    chk("fp_wrap_fwd", 32'(frame_ptr), 0);
    repeat (14) tick(1'b1, 1'b0, 7);
    tick(1'b1, 1'b0, 2);
    chk("fp_100", 32'(frame_ptr), 100);
    scroll_en = 1'b1;
    scroll_dir = 1'b0;
    scroll_step = 3'd1;
    pulse(3, 1'b1, 640);
    chk("addr_coincident", 32'(sram_addr), 24676);
    chk("fp_101", 32'(frame_ptr), 101);
    rd("rd_wrap_x0", 0, 30);
    rd("rd_wrap_x1", 1, 31);
    rd("rd_wrap_x2", 2, 0);
    wait_idle();
    chk("no_overrun_yet", 32'(fetch_overrun), 0);
    // Overrun 300 cycles into a fetch
    pulse(4, 1'b0, 300);
    repeat (299) @(negedge clk);
    pulse(5, 1'b0, 640);
    chk("overrun_set", 32'(fetch_overrun), 1);
    chk("overrun_restart", 32'(sram_addr), exp_addr(5, 101, 0));
    rd("rd_partial_invalid", 10, 0);
    wait_idle();
    chk("overrun_held", 32'(fetch_overrun), 1);
    // Reset 200 cycles into a fetch
    pulse(6, 1'b0, 201);
    rd_x = 10'd3;
    @(negedge clk);
    chk("rd_line5_x3", 32'(rd_pixel), 8);
    repeat (199) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_oe_n", 32'(sram_oe_n), 1);
    chk("mid_rst_busy", 32'(fetch_busy), 0);
    chk("mid_rst_fp", 32'(frame_ptr), 0);
    chk("mid_rst_overrun", 32'(fetch_overrun), 0);
    reset = 1'b0;
    fp = '0;
    rd("post_rst_x0", 0, 0);
    rd("post_rst_x3", 3, 0);
    rd("post_rst_x37", 37, 0);
    rd("post_rst_x639", 639, 0);
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
